// File: rtl/round_timer.sv
// round_timer: per-round countdown for the guessing game.
// A prescaler turns clk into one-second ticks. The round time is loaded by difficulty.
// The timer supports hold (pause), wrong-guess penalties and expiry reporting.
module round_timer #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned CNT_W     = 7,
    parameter int unsigned T_LVL1    = 30,
    parameter int unsigned T_LVL2    = 60,
    parameter int unsigned T_LVL3    = 90,
    parameter int unsigned PENALTY   = 5,
    parameter int unsigned WARN_SECS = 10
) (
    input  logic             clk,
    input  logic             restart,
    input  logic             start,
    input  logic [1:0]       max_digit,
    input  logic             hold,
    input  logic             penalty,
    output logic [CNT_W-1:0] seconds_left,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             timeout_pulse,
    output logic             warn
);

    localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned EXT_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  secs_q, secs_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic              tpulse_q, tpulse_d;

    logic              tick_c;
    logic              start_ok_c;
    logic [CNT_W-1:0]  load_c;
    logic [EXT_W-1:0]  secs_ext_c;
    logic [EXT_W-1:0]  dec_c;

    // Tick, load value and decrement amount for the current cycle
    always_comb begin
        tick_c     = (ps_q == PS_W'(TICK_DIV - 1));
        start_ok_c = start && (max_digit != 2'd0);
        case (max_digit)
            2'd1:    load_c = CNT_W'(T_LVL1);
            2'd2:    load_c = CNT_W'(T_LVL2);
            2'd3:    load_c = CNT_W'(T_LVL3);
            default: load_c = '0;
        endcase
        secs_ext_c = {1'b0, secs_q};
        dec_c      = (tick_c  ? EXT_W'(1)       : EXT_W'(0))
                   + (penalty ? EXT_W'(PENALTY) : EXT_W'(0));
    end

    // Next-state and next-count logic; start overrides everything but restart
    always_comb begin
        state_d  = state_q;
        secs_d   = secs_q;
        ps_d     = ps_q;
        tpulse_d = 1'b0;
        if (start_ok_c) begin
            secs_d  = load_c;
            ps_d    = '0;
            state_d = hold ? S_PAUSED : S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (hold) begin
                        state_d = S_PAUSED;
                    end else begin
                        ps_d = tick_c ? '0 : ps_q + PS_W'(1);
                        if (secs_ext_c <= dec_c) begin
                            secs_d   = '0;
                            state_d  = S_EXPIRED;
                            tpulse_d = 1'b1;
                        end else begin
                            secs_d = CNT_W'(secs_ext_c - dec_c);
                        end
                    end
                end
                S_PAUSED: begin
                    if (!hold) state_d = S_RUN;
                end
                default: begin
                    secs_d = '0;
                end
            endcase
        end
    end

    // State, count, prescaler and pulse registers with synchronous restart
    always_ff @(posedge clk) begin
        if (restart) begin
            state_q  <= S_IDLE;
            secs_q   <= '0;
            ps_q     <= '0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            secs_q   <= secs_d;
            ps_q     <= ps_d;
            tpulse_q <= tpulse_d;
        end
    end

    // Output decode straight from registers
    always_comb begin
        seconds_left  = secs_q;
        sec_tens      = 4'(secs_q / CNT_W'(10));
        sec_ones      = 4'(secs_q % CNT_W'(10));
        running       = (state_q == S_RUN);
        paused        = (state_q == S_PAUSED);
        expired       = (state_q == S_EXPIRED);
        timeout_pulse = tpulse_q;
        warn          = ((state_q == S_RUN) || (state_q == S_PAUSED))
                        && (secs_q != '0) && (secs_q <= CNT_W'(WARN_SECS));
    end

endmodule

// File: tb/tb_round_timer.sv
// Bench for round_timer: scoreboard of per-cycle expected outputs plus directed checks.
module tb_round_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       restart = 1'b0, start = 1'b0, hold = 1'b0, penalty = 1'b0;
    logic [1:0] max_digit = 2'd0;
    logic [6:0] seconds_left;
    logic [3:0] sec_tens, sec_ones;
    logic       running, paused, expired, timeout_pulse, warn;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state: 0 idle, 1 run, 2 paused, 3 expired
    int m_st = 0, m_sl = 0, m_ps = 0, m_tp = 0;
    logic [19:0] exp_q[$];

    round_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .restart(restart), .start(start), .max_digit(max_digit),
        .hold(hold), .penalty(penalty), .seconds_left(seconds_left),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running),
        .paused(paused), .expired(expired), .timeout_pulse(timeout_pulse), .warn(warn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic logic [19:0] model_word();
        logic [19:0] w;
        logic        wn;
        wn = (m_st == 1 || m_st == 2) && m_sl > 0 && m_sl <= 10;
        w  = {7'(m_sl), 4'(m_sl / 10), 4'(m_sl % 10),
              (m_st == 1), (m_st == 2), (m_st == 3), (m_tp != 0), wn};
        return w;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        int lvl [4] = '{0, 30, 60, 90};
        int d;
        m_tp = 0;
        if (restart) begin
            m_st = 0; m_sl = 0; m_ps = 0;
        end else if (start && max_digit != 0) begin
            m_sl = lvl[max_digit];
            m_ps = 0;
            m_st = hold ? 2 : 1;
        end else if (m_st == 1) begin
            if (hold) m_st = 2;
            else begin
                d    = ((m_ps == TD - 1) ? 1 : 0) + (penalty ? 5 : 0);
                m_ps = (m_ps + 1) % TD;
                if (m_sl <= d) begin
                    m_sl = 0; m_st = 3; m_tp = 1;
                end else m_sl = m_sl - d;
            end
        end else if (m_st == 2) begin
            if (!hold) m_st = 1;
        end
    endtask

    // One clock: push expectation, clock, compare against popped entry
    task automatic cyc();
        logic [19:0] want;
        model_step();
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
            want = exp_q.pop_front();
            chk("sb", {12'd0, seconds_left, sec_tens, sec_ones, running, paused,
                       expired, timeout_pulse, warn}, {12'd0, want});
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_start(input logic [1:0] md, input logic h);
        start = 1'b1; max_digit = md; hold = h;
        cyc();
        start = 1'b0; max_digit = 2'd0;
    endtask

    task automatic do_restart();
        restart = 1'b1; cyc(); restart = 1'b0;
    endtask

    initial begin
        int guard;
        #2;
        // 1: reset, load 30, first tick, expiry
        do_restart();
        chk("rst_secs", 32'(seconds_left), 32'd0);
        chk("rst_flags", {27'd0, running, paused, expired, timeout_pulse, warn}, 32'd0);
        chk("rst_bcd", {24'd0, sec_tens, sec_ones}, 32'd0);
        pulse_start(2'd1, 1'b0);
        chk("t1_load", 32'(seconds_left), 32'd30);
        chk("t1_run", 32'(running), 32'd1);
        cycles(4);
        chk("t1_tick", 32'(seconds_left), 32'd29);
        cycles(115);
        chk("t1_one", 32'(seconds_left), 32'd1);
        cyc();
        chk("t1_zero", 32'(seconds_left), 32'd0);
        chk("t1_tpulse", 32'(timeout_pulse), 32'd1);
        chk("t1_exp", 32'(expired), 32'd1);
        cyc();
        chk("t1_tpulse_off", 32'(timeout_pulse), 32'd0);
        chk("t1_exp_hold", 32'(expired), 32'd1);

        // 2: invalid difficulty from idle
        do_restart();
        pulse_start(2'd0, 1'b0);
        chk("t2_idle", {24'd0, seconds_left, running}, 32'd0);

        // 3: penalty larger than remaining time saturates at zero
        pulse_start(2'd1, 1'b0);
        cycles(108);
        chk("t3_at3", 32'(seconds_left), 32'd3);
        penalty = 1'b1; cyc(); penalty = 1'b0;
        chk("t3_sat", {29'd0, seconds_left == 0, expired, timeout_pulse}, 32'd7);
        cyc();
        chk("t3_pulse1", 32'(timeout_pulse), 32'd0);

        // 4: penalty on tick cycle, then hold/resume keeps prescaler phase
        pulse_start(2'd2, 1'b0);
        cycles(80);
        chk("t4_at40", 32'(seconds_left), 32'd40);
        cycles(3);
        penalty = 1'b1; cyc(); penalty = 1'b0;
        chk("t4_pen_tick", 32'(seconds_left), 32'd34);
        cycles(2);
        hold = 1'b1; penalty = 1'b1; cycles(20); penalty = 1'b0;
        chk("t4_paused", {24'd0, seconds_left, paused}, {24'd0, 7'd34, 1'b1});
        hold = 1'b0; cyc();
        chk("t4_resume", 32'(running), 32'd1);
        cyc();
        chk("t4_phase_a", 32'(seconds_left), 32'd34);
        cyc();
        chk("t4_phase_b", 32'(seconds_left), 32'd33);

        // 5: restart mid-round, then leave expired with level 3
        pulse_start(2'd3, 1'b0);
        cycles(180);
        chk("t5_at45", 32'(seconds_left), 32'd45);
        do_restart();
        chk("t5_rst", {24'd0, seconds_left, running}, 32'd0);
        pulse_start(2'd1, 1'b0);
        penalty = 1'b1; cycles(6); penalty = 1'b0;
        hold = 1'b1; cycles(3); hold = 1'b0;
        chk("t5_expired", 32'(expired), 32'd1);
        pulse_start(2'd3, 1'b0);
        chk("t5_reload", {20'd0, seconds_left, running, sec_tens},
            {20'd0, 7'd90, 1'b1, 4'd9});
        chk("t5_ones", 32'(sec_ones), 32'd0);

        // 6: start while holding, release, warn window
        pulse_start(2'd2, 1'b1);
        chk("t6_paused60", {24'd0, seconds_left, paused}, {24'd0, 7'd60, 1'b1});
        cycles(3);
        hold = 1'b0; cyc();
        chk("t6_run", 32'(running), 32'd1);
        guard = 0;
        while (seconds_left > 7'd10 && guard < 400) begin cyc(); guard++; end
        chk("t6_warn_on", {24'd0, seconds_left, warn}, {24'd0, 7'd10, 1'b1});
        guard = 0;
        while (!expired && guard < 100) begin cyc(); guard++; end
        chk("t6_warn_off", {30'd0, expired, warn}, 32'd2);

        // random mix, scoreboard only
        for (int i = 0; i < 400; i++) begin
            restart   = ($urandom_range(0, 99) < 1);
            start     = ($urandom_range(0, 99) < 3);
            max_digit = 2'($urandom_range(1, 3));
            hold      = ($urandom_range(0, 99) < 15);
            penalty   = ($urandom_range(0, 99) < 10);
            cyc();
        end
        restart = 1'b0; start = 1'b0; hold = 1'b0; penalty = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
